// File: rtl/adder_subtractor.sv
// rtl/adder_subtractor.sv - bit-sliced registered adder/subtractor/logic unit with carry, overflow, zero and negative flags
module adder_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       cntrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    logic             is_arith;
    logic             invert_b;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] slice_out;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_out_d, carry_out_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             negative_d, negative_q;

    assign is_arith = (cntrl[2:1] == 2'b01);
    assign invert_b = is_arith & cntrl[0];
    assign carry[0] = cntrl[0];

    // One full adder/subtractor plus 8:1 operation mux per bit; carry ripples upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic       b_eff;
        logic       sum;
        logic [7:0] sel_in;

        assign b_eff      = B[i] ^ invert_b;
        assign sum        = A[i] ^ b_eff ^ carry[i];
        assign carry[i+1] = (A[i] & b_eff) | (A[i] & carry[i]) | (b_eff & carry[i]);

        assign sel_in = {1'b0, A[i] ^ B[i], A[i] | B[i], A[i] & B[i],
                         sum, sum, 1'b0, B[i]};
        assign slice_out[i] = sel_in[cntrl];
    end

    always_comb begin
        result_d    = slice_out;
        carry_out_d = is_arith & carry[WIDTH];
        overflow_d  = is_arith & (carry[WIDTH-1] ^ carry[WIDTH]);
        zero_d      = (slice_out == '0);
        negative_d  = slice_out[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
            negative_q  <= 1'b0;
        end else begin
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// tb/tb_adder_subtractor.sv - directed and random scoreboard bench for adder_subtractor
module tb_adder_subtractor;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   cntrl = 3'b000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] result;
    logic         carry_out, overflow, zero, negative;

    typedef struct {
        string        tag;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    adder_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cntrl     (cntrl),
        .A         (A),
        .B         (B),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(string tag, logic rst, logic [2:0] c,
                                   logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        e.tag = tag;
        e.c = 1'b0;
        e.o = 1'b0;
        if (rst) begin
            e.r = '0;
        end else begin
            case (c)
                3'b000: e.r = b;
                3'b010: begin
                    e.r = a + b;
                    e.c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
                    e.o = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
                end
                3'b011: begin
                    e.r = a - b;
                    e.c = (a >= b);
                    e.o = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
                end
                3'b100: e.r = a & b;
                3'b101: e.r = a | b;
                3'b110: e.r = a ^ b;
                default: e.r = '0;
            endcase
        end
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag, logic rst, logic [2:0] c,
                        logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        reset = rst;
        cntrl = c;
        A     = a;
        B     = b;
        sb_q.push_back(model(tag, rst, c, a, b));
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".result"},    result,          e.r);
            check({e.tag, ".carry_out"}, W'(carry_out),   W'(e.c));
            check({e.tag, ".overflow"},  W'(overflow),    W'(e.o));
            check({e.tag, ".zero"},      W'(zero),        W'(e.z));
            check({e.tag, ".negative"},  W'(negative),    W'(e.n));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rc;

        step("reset",      1'b1, 3'b010, 64'h1234, 64'h5678);
        step("add_ovf",    1'b0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step("sub_eq",     1'b0, 3'b011, 64'd5, 64'd5);
        step("sub_borrow", 1'b0, 3'b011, 64'd0, 64'd1);
        step("and",        1'b0, 3'b100, 64'hF0F0, 64'hFF00);
        step("or",         1'b0, 3'b101, 64'hF0F0, 64'hFF00);
        step("xor",        1'b0, 3'b110, 64'hF0F0, 64'hFF00);
        step("pass_b",     1'b0, 3'b000, 64'hF0F0, 64'hFF00);
        step("add_wrap",   1'b0, 3'b010, {W{1'b1}}, {W{1'b1}});
        step("reset_mid",  1'b1, 3'b010, {W{1'b1}}, {W{1'b1}});
        step("zero_001",   1'b0, 3'b001, {W{1'b1}}, 64'hDEAD_BEEF);
        step("zero_111",   1'b0, 3'b111, 64'h8000_0000_0000_0000, {W{1'b1}});
        step("sub_ovf",    1'b0, 3'b011, 64'h8000_0000_0000_0000, 64'd1);
        step("sub_big",    1'b0, 3'b011, {W{1'b1}}, 64'd1);

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 3'($urandom_range(0, 7));
            if (i % 8 == 0) rb = ra;
            step($sformatf("rand%0d", i), 1'b0, rc, ra, rb);
        end

        step("reset_end",  1'b1, 3'b110, 64'hAAAA, 64'h5555);
        step("resume",     1'b0, 3'b010, 64'd2, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_subtractor.md
ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result bit width (legal values 2 to 64).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cntrl, input, 3, operation select.
REQ-005 SHALL have port A, input, WIDTH, first operand.
REQ-006 SHALL have port B, input, WIDTH, second operand.
REQ-007 SHALL have port result, output, WIDTH, registered operation result.
REQ-008 SHALL have port carry_out, output, 1, registered carry out of the MSB.
REQ-009 SHALL have port overflow, output, 1, registered signed overflow.
REQ-010 SHALL have port zero, output, 1, registered flag, result == 0.
REQ-011 SHALL have port negative, output, 1, registered copy of result[WIDTH-1].

Function
REQ-012 SHALL be built as WIDTH one-bit slices, each a full adder/subtractor plus an 8:1 selection mux indexed by cntrl.
REQ-013 SHALL implement these cntrl encodings:
- 000: pass B.
- 001: all zeros.
- 010: A + B.
- 011: A - B.
- 100: A AND B.
- 101: A OR B.
- 110: A XOR B.
- 111: all zeros.
REQ-014 SHALL compute subtract as A + ~B + 1: each slice inverts B when cntrl[0]=1 and cntrl[2:1]=01, and the LSB carry-in equals cntrl[0].
REQ-015 SHALL ripple the carry from slice i to slice i+1; carry_out SHALL be the carry out of slice WIDTH-1.
REQ-016 SHALL set carry_out and overflow only for cntrl 010/011 and force both to 0 for all other encodings.
REQ-017 SHALL compute overflow as the carry into the MSB XOR the carry out of the MSB.
REQ-018 SHALL compute zero and negative from the selected WIDTH-bit result for every encoding.
REQ-019 SHALL register result and all four flags together, giving a latency of exactly 1 clock: inputs sampled at edge N appear on the outputs after edge N.
REQ-020 SHALL accept new inputs every cycle; there is no handshake, no stall and no internal state other than the output registers.
REQ-021 SHALL discard the final carry on wrap-around: the result is the sum modulo 2^WIDTH.
REQ-022 SHALL treat subtract borrow as carry_out=0: carry_out=1 means A >= B unsigned.

Reset
REQ-023 SHALL load result=0, carry_out=0, overflow=0, negative=0 and zero=1 on the first rising clk edge with reset=1.
REQ-024 SHALL give reset priority over the operand inputs; asserting reset mid-stream discards the in-flight operation.
REQ-025 SHALL resume normal 1-cycle operation on the first edge with reset=0.

Verification (WIDTH=64)
REQ-026 SHALL pass this scenario: reset=1 for 1 edge -> result=0, zero=1, and carry_out, overflow, negative all 0.
REQ-027 SHALL pass this scenario: cntrl=010, A=0x7FFFFFFFFFFFFFFF, B=1 -> one cycle later result=0x8000000000000000, overflow=1, negative=1, carry_out=0, zero=0.
REQ-028 SHALL pass this scenario: cntrl=011, A=5, B=5 -> result=0, zero=1, carry_out=1, overflow=0.
REQ-029 SHALL pass this scenario: cntrl=011, A=0, B=1 -> result=0xFFFFFFFFFFFFFFFF, carry_out=0, negative=1, overflow=0.
REQ-030 SHALL pass this scenario: A=0xF0F0, B=0xFF00 with cntrl=100/101/110/000 -> result 0xF000/0xFFF0/0x0FF0/0xFF00 respectively, carry_out=0 and overflow=0 each time.
REQ-031 SHALL pass this scenario: cntrl=010, A=B=0xFFFFFFFFFFFFFFFF, then reset=1 on the next edge -> first 0xFFFFFFFFFFFFFFFE with carry_out=1, then reset values; cntrl=001 or 111 with any operands -> result=0, zero=1.
